register_file32: RTL
====================

Name: register_file32

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle processor; sits directly upstream of the ALU and its 32-bit bitwise units (and/or/nor/xor).
- Supplies the A/B operands through two combinational read ports.
- Captures the writeback result through one synchronous write port.
- Register 0 is hardwired to zero (MIPS $zero semantics).

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH = 32

Ports:
- clk  input  1  processor clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all registers
- read_reg1  input  ADDR_WIDTH  index for operand A (rs)
- read_reg2  input  ADDR_WIDTH  index for operand B (rt)
- write_reg  input  ADDR_WIDTH  destination index (rd/rt, chosen upstream)
- write_data  input  DATA_WIDTH  writeback value (ALU result or memory data)
- reg_write  input  1  write enable from control unit
- read_data1  output  DATA_WIDTH  contents of read_reg1, feeds ALU A
- read_data2  output  DATA_WIDTH  contents of read_reg2, feeds ALU B / store data

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Storage: 32 registers, index 0..31.
- Reset: on a rising clk edge with reset=1, all 32 registers become 0x00000000.
  - reset takes priority over reg_write in the same cycle; the write is dropped.
  - Outputs are combinational views of storage, so read_data1 and read_data2 read 0 from the edge after reset onward, whatever the addresses.
  - Before the first reset edge, register contents are undefined (X in simulation). Only register 0 reads 0.
- Write: on a rising clk edge with reset=0, reg_write=1 and write_reg != 0, register[write_reg] <= write_data.
  - write_reg == 0: the write is silently discarded.
  - reg_write=0: no register changes.
  - Writes are full-width only; there are no byte enables.
- Read: fully combinational, zero-cycle latency.
  - read_dataN = 0 when read_regN == 0; otherwise register[read_regN].
  - Both ports may address the same register at the same time.
- Same-cycle read/write of the same index (macro absent): the read returns the old value. The new value is visible after the edge. This is correct for the single-cycle datapath, where the write lands at the end of the instruction.
- No handshake: the control unit guarantees that write_reg, write_data and reg_write are stable before the rising edge.
- Address inputs wider than needed do not occur; all 32 indices are legal.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN
- Defined:
  - read_dataN = write_data when reg_write=1, reset=0, write_reg != 0 and read_regN == write_reg.
  - Otherwise normal read.
  - Provides write-to-read forwarding for a future pipelined variant.
  - The bypass is purely combinational and adds no latency.
- Not defined: no forwarding; same-cycle reads return the pre-edge stored value (as in Behaviour).

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then assert reset for 1 edge. Required: read_reg1=5 gives read_data1=0x00000000. With reset=1 and reg_write=1 writing r7=0x1234 on the same edge, r7 reads 0.
- Basic write/read: write r1=0x0000000F and r31=0xFFFFFFF0 on consecutive edges, then set read_reg1=1 and read_reg2=31. Required: 0x0000000F and 0xFFFFFFF0. Feeding both into the nor unit gives 0x00000000.
- $zero: reg_write=1, write_reg=0, write_data=0xAAAAAAAA, one edge. Required: read_data1 and read_data2 with index 0 both equal 0x00000000.
- Write disabled: r3=0x11111111, then reg_write=0, write_reg=3, write_data=0x22222222, one edge. Required: r3 still reads 0x11111111.
- Same-cycle hazard: r4=0x00000001 stored; drive reg_write=1, write_reg=4, write_data=0x00000002, read_reg1=read_reg2=4.
  - Before the edge, macro undefined: both outputs 0x00000001.
  - Before the edge, macro defined: both outputs 0x00000002.
  - After the edge, either build: 0x00000002.
- Sweep: write r[i]=i*0x01010101 for i=1..31, then read every index on both ports. Required: each matches and r0=0. There must be no aliasing between indices.

Source files
------------

// File: rtl/register_file32.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port, r0 reads zero.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic                  w_wr_en;

  // Writes to r0 are dropped here; the read muxes also force r0 to zero.
  assign w_wr_en = reg_write && (write_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read_reg1 != '0) read_data1 = r_regs[read_reg1];
    if (read_reg2 != '0) read_data2 = r_regs[read_reg2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (w_wr_en && !reset && (read_reg1 == write_reg)) read_data1 = write_data;
    if (w_wr_en && !reset && (read_reg2 == write_reg)) read_data2 = write_data;
`endif
  end

endmodule
